// File: rtl/mema_feed_if.sv
// ============================================================================
// mema_feed_if : row-stream and skew-memory side signals of mema_feed_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface mema_feed_if #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
);
  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;

  logic                      start;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [BITS_AB-1:0] in_row [DIM];
  logic                      in_last;
  logic                      WrEn;
  logic                      en;
  logic signed [BITS_AB-1:0] Ain    [DIM];
  logic [RW-1:0]             Arow;
  logic                      busy;
  logic                      done;

  modport master (
    output start, in_valid, in_row, in_last,
    input  in_ready, WrEn, en, Ain, Arow, busy, done
  );

  modport slave (
    input  start, in_valid, in_row, in_last,
    output in_ready, WrEn, en, Ain, Arow, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/mema_feed_ctrl.sv
// ============================================================================
// mema_feed_ctrl : loads one DIM-row tile into the A skew memory, then drains
// Optional macro: MEMA_FEED_SHORT_TILE_EN (in_last ends a tile early, zero pad)
// Rev 1.0
// ============================================================================
`default_nettype none

module mema_feed_ctrl #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int DRAIN   = 3*DIM-2
) (
  input  wire logic  clk,
  input  wire logic  rst,
  mema_feed_if.slave bus
);
  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int DW = $clog2(DRAIN + 1);
  localparam logic [RW-1:0] c_LAST_ROW = RW'(DIM - 1);
  localparam logic [DW-1:0] c_DRAIN    = DW'(DRAIN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                    r_state, w_state_nx;
  logic [RW-1:0]             r_row_cnt, w_row_nx;
  logic [DW-1:0]             r_drain_cnt, w_drain_nx;
  logic                      r_wren, w_wren_nx;
  logic                      r_en, w_en_nx;
  logic                      r_done, w_done_nx;
  logic signed [BITS_AB-1:0] r_ain [DIM];
  logic signed [BITS_AB-1:0] w_ain_nx [DIM];
  logic [RW-1:0]             r_arow, w_arow_nx;
  logic                      w_ready;
  logic                      w_hs;

`ifdef MEMA_FEED_SHORT_TILE_EN
  logic r_pad, w_pad_nx;
  assign w_ready = (r_state == S_LOAD) && !r_pad;
`else
  assign w_ready = (r_state == S_LOAD);
`endif

  assign w_hs = bus.in_valid && w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_row_cnt   <= '0;
      r_drain_cnt <= '0;
      r_wren      <= 1'b0;
      r_en        <= 1'b0;
      r_done      <= 1'b0;
      r_ain       <= '{default: '0};
      r_arow      <= '0;
`ifdef MEMA_FEED_SHORT_TILE_EN
      r_pad       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_row_cnt   <= w_row_nx;
      r_drain_cnt <= w_drain_nx;
      r_wren      <= w_wren_nx;
      r_en        <= w_en_nx;
      r_done      <= w_done_nx;
      r_ain       <= w_ain_nx;
      r_arow      <= w_arow_nx;
`ifdef MEMA_FEED_SHORT_TILE_EN
      r_pad       <= w_pad_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_row_nx   = r_row_cnt;
    w_drain_nx = r_drain_cnt;
    w_wren_nx  = 1'b0;
    w_en_nx    = 1'b0;
    w_done_nx  = 1'b0;
    w_ain_nx   = r_ain;
    w_arow_nx  = r_arow;
`ifdef MEMA_FEED_SHORT_TILE_EN
    w_pad_nx   = r_pad;
`endif
    case (r_state)
      S_IDLE: begin
        w_row_nx   = '0;
        w_drain_nx = '0;
`ifdef MEMA_FEED_SHORT_TILE_EN
        w_pad_nx   = 1'b0;
`endif
        if (bus.start) w_state_nx = S_LOAD;
      end
      S_LOAD: begin
        if (w_hs) begin
          w_wren_nx = 1'b1;
          w_en_nx   = 1'b1;
          w_ain_nx  = bus.in_row;
          w_arow_nx = r_row_cnt;
          if (r_row_cnt == c_LAST_ROW) begin
            w_state_nx = S_DRAIN;
            w_drain_nx = '0;
          end else begin
            w_row_nx = r_row_cnt + 1'b1;
`ifdef MEMA_FEED_SHORT_TILE_EN
            if (bus.in_last) w_pad_nx = 1'b1;
`endif
          end
        end
`ifdef MEMA_FEED_SHORT_TILE_EN
        // Zero rows keep every skew lane aligned as if a full tile arrived
        else if (r_pad) begin
          w_wren_nx = 1'b1;
          w_en_nx   = 1'b1;
          w_ain_nx  = '{default: '0};
          w_arow_nx = r_row_cnt;
          if (r_row_cnt == c_LAST_ROW) begin
            w_state_nx = S_DRAIN;
            w_drain_nx = '0;
            w_pad_nx   = 1'b0;
          end else begin
            w_row_nx = r_row_cnt + 1'b1;
          end
        end
`endif
      end
      S_DRAIN: begin
        // First DRAIN cycle still presents the final write, so DRAIN
        // en-only cycles are issued before the done cycle.
        if (r_drain_cnt == c_DRAIN) begin
          w_state_nx = S_IDLE;
          w_done_nx  = 1'b1;
        end else begin
          w_en_nx    = 1'b1;
          w_ain_nx   = '{default: '0};
          w_drain_nx = r_drain_cnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign bus.in_ready = w_ready;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.WrEn     = r_wren;
  assign bus.en       = r_en;
  assign bus.done     = r_done;
  assign bus.Ain      = r_ain;
  assign bus.Arow     = r_arow;
endmodule

`default_nettype wire

// File: tb/tb_mema_feed_ctrl.sv
// ============================================================================
// tb_mema_feed_ctrl : directed self-checking bench for mema_feed_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mema_feed_ctrl;
  localparam int BITS_AB = 8;
  localparam int DIM     = 8;
  localparam int DRAIN   = 3*DIM-2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  mema_feed_if #(.BITS_AB(BITS_AB), .DIM(DIM)) bus ();

  mema_feed_ctrl #(.BITS_AB(BITS_AB), .DIM(DIM), .DRAIN(DRAIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] row_word(input int r);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < DIM; c++) v[c*BITS_AB +: BITS_AB] = BITS_AB'(r*DIM + c);
    return v;
  endfunction

  function automatic logic [63:0] ain_word();
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < DIM; c++) v[c*BITS_AB +: BITS_AB] = bus.Ain[c];
    return v;
  endfunction

  task automatic set_row(input int r);
    for (int c = 0; c < DIM; c++) bus.in_row[c] = BITS_AB'(r*DIM + c);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_wren"},  bus.WrEn,     0);
    chk({tag, "_en"},    bus.en,       0);
    chk({tag, "_done"},  bus.done,     0);
    chk({tag, "_busy"},  bus.busy,     0);
    chk({tag, "_ready"}, bus.in_ready, 0);
    chk({tag, "_ain"},   ain_word(),   0);
    chk({tag, "_arow"},  bus.Arow,     0);
  endtask

  // One tile: real_rows rows are offered, in_last on row last_idx.
  task automatic do_tile(input bit bubbles, input bit poke, input int abort_at,
                         input int real_rows, input int last_idx);
    int sent = 0, writes = 0, drains = 0, dones = 0, ready_cyc = 0, gap = 0, ph = 0;
    bit hs, fin = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("load_ready", bus.in_ready, 1);
    chk("load_busy",  bus.busy,     1);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      bus.in_valid = (sent < real_rows) && !(bubbles && (ph % 2 == 1));
      set_row(sent);
      bus.in_last  = (sent == last_idx);
      bus.start    = poke && (writes == 3 || drains == 10);
      hs = bus.in_valid && bus.in_ready;
      if (bus.in_ready) ready_cyc++;
      if (sent < real_rows) ph++;
      tick();
      if (hs) sent++;
      if (real_rows == DIM) chk("wren_latency", bus.WrEn, hs);
      if (bus.WrEn) begin
        chk("arow", bus.Arow, writes);
        chk("ain", ain_word(), (writes < real_rows) ? row_word(writes) : 64'd0);
        chk("en_with_wren", bus.en, 1);
        if (writes >= real_rows) chk("pad_ready", bus.in_ready, 0);
        writes++;
      end else if (bus.en) begin
        chk("drain_ain", ain_word(), 0);
        drains++;
      end else if (writes == DIM && !bus.done) begin
        gap++;
      end
      if (bus.done) begin
        dones++;
        chk("done_busy", bus.busy, 0);
        chk("done_en",   bus.en,   0);
        fin = 1'b1;
      end
      if (abort_at >= 0 && drains == abort_at && bus.en && !bus.WrEn) begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_quiet("abort");
        for (int k = 0; k < 30; k++) begin
          tick();
          if (bus.done) dones++;
        end
        chk("abort_no_done", dones, 0);
        return;
      end
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("timeout", fin, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.done) dones++;
    end
    chk("writes", writes, DIM);
    chk("drains", drains, DRAIN);
    chk("dones",  dones,  1);
    chk("gap",    gap,    0);
    if (bubbles) chk("load_cycles", ready_cyc, 15);
  endtask

  initial begin
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    set_row(5);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_quiet("reset");
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk_quiet("idle");

    do_tile(1'b0, 1'b0, -1, DIM, -1);
    do_tile(1'b1, 1'b0, -1, DIM, -1);
    do_tile(1'b0, 1'b1, -1, DIM, -1);
    do_tile(1'b0, 1'b0, 5,  DIM, -1);
    do_tile(1'b0, 1'b0, -1, DIM, -1);
`ifdef MEMA_FEED_SHORT_TILE_EN
    do_tile(1'b0, 1'b0, -1, 3, 2);
`else
    do_tile(1'b0, 1'b0, -1, DIM, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
